// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch handshake between the PC fetch controller and imem.
interface pc_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;

   modport master (output imem_req, output imem_addr, input imem_ack);
   modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_controller.sv
// PC register and single-outstanding instruction fetch sequencer for the MIPS IF stage.
// Redirects arriving mid-fetch are held pending and squash the fetch when it completes.
module pc_fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        halt,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   pc_fetch_if.master  imem,
   output logic [31:0] pc_out,
   output logic        inst_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] epc,
   output logic        halted
);
   localparam int unsigned AW = 32;
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

   typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

   state_t        state, state_d;
   logic [AW-1:0] pc_d, epc_d, fetch_pc_d, pend_target, pend_target_d;
   logic          inst_valid_d, pend_valid, pend_valid_d, pend_exc, pend_exc_d;
   logic          halt_req, halt_req_d, req_q;

   // Redirect arriving this cycle, resolved by priority exc > jump > branch.
   logic          rd_valid;
   logic [AW-1:0] rd_target;
   assign rd_valid  = exc_valid | jump_valid | branch_valid;
   assign rd_target = exc_valid  ? (EXC_VECTOR & ALIGN_MASK) :
                      jump_valid ? (jump_target & ALIGN_MASK) :
                                   (branch_target & ALIGN_MASK);

   // Merge with the pending redirect; a pending exception is only displaced by another exception.
   logic          keep_pend, merge_valid, merge_exc;
   logic [AW-1:0] merge_target;
   assign keep_pend    = pend_valid & pend_exc & ~exc_valid;
   assign merge_valid  = pend_valid | rd_valid;
   assign merge_target = (rd_valid && !keep_pend) ? rd_target : pend_target;
   assign merge_exc    = (rd_valid && !keep_pend) ? exc_valid : pend_exc;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc_out      <= RESET_VECTOR & ALIGN_MASK;
         epc         <= '0;
         fetch_pc    <= '0;
         inst_valid  <= 1'b0;
         pend_valid  <= 1'b0;
         pend_exc    <= 1'b0;
         pend_target <= '0;
         halt_req    <= 1'b0;
         req_q       <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state       <= state_d;
         pc_out      <= pc_d;
         epc         <= epc_d;
         fetch_pc    <= fetch_pc_d;
         inst_valid  <= inst_valid_d;
         pend_valid  <= pend_valid_d;
         pend_exc    <= pend_exc_d;
         pend_target <= pend_target_d;
         halt_req    <= halt_req_d;
         req_q       <= (state_d == REQ);
         halted      <= (state_d == HALT);
      end
   end

   always_comb begin
      state_d       = state;
      pc_d          = pc_out;
      epc_d         = epc;
      fetch_pc_d    = fetch_pc;
      inst_valid_d  = 1'b0;
      pend_valid_d  = pend_valid;
      pend_exc_d    = pend_exc;
      pend_target_d = pend_target;
      halt_req_d    = halt_req | halt;

      if (exc_valid) epc_d = exc_pc;

      case (state)
         IDLE: begin
            if (rd_valid) pc_d = rd_target;
            if (halt_req_d)  state_d = HALT;
            else if (!stall) state_d = REQ;
         end
         REQ: begin
            if (imem.imem_ack) begin
               if (merge_valid) begin
                  pc_d         = merge_target;
                  pend_valid_d = 1'b0;
                  pend_exc_d   = 1'b0;
               end else begin
                  inst_valid_d = 1'b1;
                  fetch_pc_d   = pc_out;
                  pc_d         = pc_out + AW'(4);
               end
               if (halt_req_d) state_d = HALT;
               else if (stall) state_d = IDLE;
               else            state_d = REQ;
            end else if (rd_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = merge_target;
               pend_exc_d    = merge_exc;
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_pc_fetch_controller.sv
// Randomized self-checking bench: behavioural fetch model plus a scoreboard of delivered fetch addresses.
module tb_pc_fetch_controller;
   logic        clk = 1'b0;
   logic        reset, stall, halt;
   logic        branch_valid, jump_valid, exc_valid;
   logic [31:0] branch_target, jump_target, exc_pc;
   logic [31:0] pc_out, fetch_pc, epc;
   logic        inst_valid, halted;

   pc_fetch_if imem_bus();

   pc_fetch_controller dut (
      .clk(clk), .reset(reset), .stall(stall), .halt(halt),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .exc_valid(exc_valid), .exc_pc(exc_pc),
      .imem(imem_bus.master),
      .pc_out(pc_out), .inst_valid(inst_valid), .fetch_pc(fetch_pc),
      .epc(epc), .halted(halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // Model: the block is either waiting, fetching, or stopped for good.
   localparam int WAITING  = 0;
   localparam int FETCHING = 1;
   localparam int STOPPED  = 2;
   int          m_mode;
   logic [31:0] m_pc, m_epc, m_pend_target;
   logic        m_pend, m_pend_is_exc, m_halt_seen, m_iv;
   int          stopped_cycles;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 5))
         0: t = 32'hFFFF_FFFC;
         1: t = 32'h0000_0203;
         2: t = 32'hFFFF_FFF5;
         default: t = $urandom;
      endcase
      return t;
   endfunction

   // Advance the reference model by one clock using the inputs the bench is driving.
   task automatic model_step();
      logic        redirect;
      logic [31:0] target;
      m_iv = 1'b0;
      if (reset) begin
         m_mode = WAITING; m_pc = 32'h0; m_epc = 32'h0;
         m_pend = 1'b0; m_pend_is_exc = 1'b0; m_halt_seen = 1'b0;
         return;
      end
      if (halt) m_halt_seen = 1'b1;
      if (exc_valid) m_epc = exc_pc;
      redirect = exc_valid || jump_valid || branch_valid;
      if (exc_valid)       target = 32'h80;
      else if (jump_valid) target = {jump_target[31:2], 2'b00};
      else                 target = {branch_target[31:2], 2'b00};

      if (m_mode == WAITING) begin
         if (redirect) m_pc = target;
         if (m_halt_seen) m_mode = STOPPED;
         else if (!stall) m_mode = FETCHING;
      end else if (m_mode == FETCHING) begin
         if (imem_bus.imem_ack) begin
            if (m_pend || redirect) begin
               // Newest redirect wins unless it would displace a pending exception with a non-exception.
               if (redirect && !(m_pend && m_pend_is_exc && !exc_valid)) m_pc = target;
               else m_pc = m_pend_target;
               m_pend = 1'b0;
               m_pend_is_exc = 1'b0;
            end else begin
               exp_q.push_back(m_pc);
               m_iv = 1'b1;
               m_pc = m_pc + 32'd4;
            end
            if (m_halt_seen) m_mode = STOPPED;
            else if (stall) m_mode = WAITING;
         end else if (redirect) begin
            if (!(m_pend && m_pend_is_exc && !exc_valid)) begin
               m_pend_target = target;
               m_pend_is_exc = exc_valid;
            end
            m_pend = 1'b1;
         end
      end
   endtask

   // Monitor: every delivered instruction must match the oldest predicted fetch address.
   always @(negedge clk) begin
      if (inst_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_pc_unexpected: got inst_valid with fetch_pc %h, expected none", fetch_pc);
         end else begin
            chk("fetch_pc", fetch_pc, exp_q.pop_front());
         end
      end
   end

   task automatic drive_quiet(input logic rst);
      reset = rst; stall = 1'b0; halt = 1'b0;
      branch_valid = 1'b0; jump_valid = 1'b0; exc_valid = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0; exc_pc = 32'h0;
      imem_bus.imem_ack = 1'b1;
   endtask

   initial begin
      stopped_cycles = 0;
      m_mode = WAITING; m_pc = 32'h0; m_epc = 32'h0; m_pend_target = 32'h0;
      m_pend = 1'b0; m_pend_is_exc = 1'b0; m_halt_seen = 1'b0; m_iv = 1'b0;
      drive_quiet(1'b1);
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         #1;
         chk("pc_out",     pc_out,                 m_pc);
         chk("imem_addr",  imem_bus.imem_addr,     m_pc);
         chk("imem_req",   32'(imem_bus.imem_req), 32'(m_mode == FETCHING));
         chk("halted",     32'(halted),            32'(m_mode == STOPPED));
         chk("epc",        epc,                    m_epc);
         chk("inst_valid", 32'(inst_valid),        32'(m_iv));

         stopped_cycles = (m_mode == STOPPED) ? stopped_cycles + 1 : 0;
         if (cyc < 3) begin
            drive_quiet(1'b1);
         end else if (cyc < 15) begin
            drive_quiet(1'b0);
         end else begin
            reset = (stopped_cycles > 8) || ($urandom_range(0, 299) == 0);
            halt  = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 3) == 0);
            imem_bus.imem_ack = ($urandom_range(0, 2) != 0);
            exc_valid    = ($urandom_range(0, 15) == 0);
            jump_valid   = ($urandom_range(0, 11) == 0);
            branch_valid = ($urandom_range(0, 9) == 0);
            jump_target   = pick_target();
            branch_target = pick_target();
            exc_pc        = $urandom;
         end
      end
      @(negedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
